// File: rtl/oob_link_sup_pkg.sv
// Shared types and helpers for the OOB link supervisor: the state encoding,
// SATA generation codes and timeout scaling by clock speed grade.
package oob_link_sup_pkg;

   typedef enum logic [2:0] {
      WAIT_GTX,
      RST,
      WAIT_LINK,
      LINK,
      FAIL,
      RATE
   } state_e;

   localparam logic [1:0] GEN1 = 2'd1;
   localparam logic [1:0] GEN2 = 2'd2;
   localparam logic [1:0] GEN3 = 2'd3;

   // Timeouts are specified at 75 MHz; faster usrclk2 grades need more cycles.
   function automatic int scale_timeout(input int cycles, input int grade);
      return cycles * grade;
   endfunction

endpackage

// File: rtl/oob_link_sup_timer.sv
// Loadable down-counter shared by every timed supervisor state. It stops at
// zero and flags expiry while the count is zero.
module oob_link_sup_timer #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         expired_o
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] cnt_q;

   // Reload on request, otherwise count down and hold at zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - ONE;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/oob_link_sup.sv
// OOB link supervisor: sequences OOB controller reset, bring-up timeouts,
// retries and Gen-rate fallback via a req/ack handshake with the GTX rate logic.
// Optional build macro OOB_LINK_SUP_STATS_EN adds link_drops_o/attempts_o
// saturating statistics counters.
module oob_link_sup
   import oob_link_sup_pkg::*;
#(
   parameter int CLK_SPEED_GRADE = 1,
   parameter int MAX_GEN         = 2,
   parameter int RST_CYCLES      = 16,
   parameter int LINK_TIMEOUT    = 32768,
   parameter int RETRIES_PER_GEN = 2,
   parameter int RATE_TIMEOUT    = 4096
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        gtx_ready_i,
   input  logic        phy_ready_i,
   input  logic        comreset_req_i,
   output logic        oob_rst_o,
   output logic [1:0]  rate_sel_o,
   output logic        rate_req_o,
   input  logic        rate_ack_i,
   output logic [1:0]  link_gen_o,
   output logic        busy_o,
   output logic        err_nolink_o,
   output logic        err_rate_o
`ifdef OOB_LINK_SUP_STATS_EN
   ,
   output logic [15:0] link_drops_o,
   output logic [15:0] attempts_o
`endif
);

   localparam int              LINK_CYC  = scale_timeout(LINK_TIMEOUT, CLK_SPEED_GRADE);
   localparam int              TW        = $clog2(LINK_CYC + 1);
   localparam int              RW        = $clog2(RETRIES_PER_GEN + 1);
   localparam logic [TW-1:0]   RST_LOAD  = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0]   LINK_LOAD = TW'(LINK_CYC - 1);
   localparam logic [TW-1:0]   RATE_LOAD = TW'(RATE_TIMEOUT - 1);
   localparam logic [1:0]      MAX_SEL   = 2'(MAX_GEN);

   state_e          state_q, state_d;
   logic            oob_rst_q, oob_rst_d;
   logic [1:0]      rate_sel_q, rate_sel_d;
   logic            rate_req_q, rate_req_d;
   logic [1:0]      link_gen_q, link_gen_d;
   logic            busy_q, busy_d;
   logic            err_nolink_q, err_nolink_d;
   logic            err_rate_q, err_rate_d;
   logic [RW-1:0]   retry_cnt_q, retry_cnt_d;
   logic            timer_load;
   logic [TW-1:0]   timer_val;
   logic            timer_exp;

   oob_link_sup_timer #(.W(TW)) u_timer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (timer_load),
      .load_val_i (timer_val),
      .expired_o  (timer_exp)
   );

   // Next-state and next-output decode; outputs are derived from the next
   // state so they are registered together with it.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves a latch.
      state_d      = state_q;
      rate_sel_d   = rate_sel_q;
      err_nolink_d = err_nolink_q;
      err_rate_d   = err_rate_q;
      retry_cnt_d  = retry_cnt_q;

      if (!gtx_ready_i && state_q != WAIT_GTX) begin
         // Losing the transceiver overrides everything else in flight.
         state_d = WAIT_GTX;
      end else begin
         case (state_q)
            WAIT_GTX:  if (gtx_ready_i) state_d = RST;
            RST:       if (timer_exp) state_d = WAIT_LINK;
            WAIT_LINK: begin
               // A link arriving on the expiry cycle still counts as success.
               if (phy_ready_i) begin
                  state_d      = LINK;
                  err_nolink_d = 1'b0;
               end else if (comreset_req_i) begin
                  state_d = RST;
               end else if (timer_exp) begin
                  state_d = FAIL;
               end
            end
            LINK: begin
               if (!phy_ready_i) begin
                  // Lost link gets a fresh retry budget at the same rate.
                  state_d     = RST;
                  retry_cnt_d = '0;
               end else if (comreset_req_i) begin
                  state_d = RST;
               end
            end
            FAIL: begin
               if (int'(retry_cnt_q) + 1 < RETRIES_PER_GEN) begin
                  retry_cnt_d = retry_cnt_q + RW'(1);
                  state_d     = RST;
               end else begin
                  retry_cnt_d = '0;
                  state_d     = RATE;
                  if (rate_sel_q > GEN1) begin
                     rate_sel_d = rate_sel_q - 2'd1;
                  end else begin
                     // Every rate failed: flag it and start over from the top.
                     err_nolink_d = 1'b1;
                     rate_sel_d   = MAX_SEL;
                  end
               end
            end
            RATE: begin
               if (rate_ack_i) begin
                  state_d = RST;
               end else if (timer_exp) begin
                  err_rate_d = 1'b1;
                  state_d    = WAIT_GTX;
               end
            end
            default: state_d = WAIT_GTX;
         endcase
      end

      // FAIL keeps the OOB controller in reset so each attempt window is exact.
      oob_rst_d  = (state_d inside {WAIT_GTX, RST, FAIL, RATE});
      rate_req_d = (state_d == RATE);
      busy_d     = (state_d != LINK);
      link_gen_d = (state_d == LINK) ? rate_sel_q : 2'd0;

      // Every transition changes state, so a state change is a timer reload.
      timer_load = (state_d != state_q);
      case (state_d)
         RST:       timer_val = RST_LOAD;
         WAIT_LINK: timer_val = LINK_LOAD;
         RATE:      timer_val = RATE_LOAD;
         default:   timer_val = '0;
      endcase
   end

   // State and registered outputs with synchronous reset.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst_i) begin
         state_q      <= WAIT_GTX;
         oob_rst_q    <= 1'b1;
         rate_sel_q   <= MAX_SEL;
         rate_req_q   <= 1'b0;
         link_gen_q   <= 2'd0;
         busy_q       <= 1'b1;
         err_nolink_q <= 1'b0;
         err_rate_q   <= 1'b0;
         retry_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         oob_rst_q    <= oob_rst_d;
         rate_sel_q   <= rate_sel_d;
         rate_req_q   <= rate_req_d;
         link_gen_q   <= link_gen_d;
         busy_q       <= busy_d;
         err_nolink_q <= err_nolink_d;
         err_rate_q   <= err_rate_d;
         retry_cnt_q  <= retry_cnt_d;
      end
   end

   assign oob_rst_o    = oob_rst_q;
   assign rate_sel_o   = rate_sel_q;
   assign rate_req_o   = rate_req_q;
   assign link_gen_o   = link_gen_q;
   assign busy_o       = busy_q;
   assign err_nolink_o = err_nolink_q;
   assign err_rate_o   = err_rate_q;

`ifdef OOB_LINK_SUP_STATS_EN
   logic [15:0] link_drops_q, attempts_q;
   logic        drop_evt, fail_evt;

   assign drop_evt = (state_q == LINK) && gtx_ready_i && !phy_ready_i;
   assign fail_evt = (state_d == FAIL) && (state_q != FAIL);

   // Saturating counts of link drops and failed bring-up attempts.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         link_drops_q <= 16'd0;
         attempts_q   <= 16'd0;
      end else begin
         if (drop_evt && link_drops_q != 16'hFFFF) link_drops_q <= link_drops_q + 16'd1;
         if (fail_evt && attempts_q != 16'hFFFF)   attempts_q   <= attempts_q + 16'd1;
      end
   end

   assign link_drops_o = link_drops_q;
   assign attempts_o   = attempts_q;
`endif

endmodule
